// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: passes M[0..15] through, then expands W[16..63] in a 16-word window.
// Optional build macro SHA256_SCHED_OVERRUN_ERR_EN adds a sticky overrun_err_o flag.

module sha256_msg_schedule #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [WORD_W-1:0] M_i,
    output logic              in_ready_o,
    output logic              w_valid_o,
    output logic [WORD_W-1:0] W_o,
    output logic [5:0]        round_o,
    output logic              block_done_o
`ifdef SHA256_SCHED_OVERRUN_ERR_EN
    ,
    output logic              overrun_err_o
`endif
);

    typedef enum logic [0:0] {
        ST_LOAD   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    localparam logic [5:0] LAST_LOAD  = 6'd15;
    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
        small_sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
        small_sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

    state_t            state_r;
    logic [5:0]        cnt_r;
    logic [WORD_W-1:0] win_r [16];
    logic [WORD_W-1:0] expand_s;
    logic              shift_en_s;
    logic [WORD_W-1:0] shift_word_s;

    // Next schedule word and the word entering the window this cycle.
    always_comb begin
        expand_s     = small_sigma1(win_r[14]) + win_r[9] + small_sigma0(win_r[1]) + win_r[0];
        shift_en_s   = 1'b0;
        shift_word_s = M_i;
        if (state_r == ST_EXPAND) begin
            shift_en_s   = 1'b1;
            shift_word_s = expand_s;
        end else begin
            shift_en_s   = valid_i;
            shift_word_s = M_i;
        end
    end

    // Sliding window: win_r[15] newest, win_r[0] oldest.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) win_r[i] <= {WORD_W{1'b0}};
        end else if (shift_en_s) begin
            for (int i = 0; i < 15; i++) win_r[i] <= win_r[i+1];
            win_r[15] <= shift_word_s;
        end else begin
            for (int i = 0; i < 16; i++) win_r[i] <= win_r[i];
        end
    end

    // Load/expand control and registered output stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_LOAD;
            cnt_r        <= 6'd0;
            in_ready_o   <= 1'b1;
            w_valid_o    <= 1'b0;
            W_o          <= {WORD_W{1'b0}};
            round_o      <= 6'd0;
            block_done_o <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    block_done_o <= 1'b0;
                    if (valid_i) begin
                        W_o       <= M_i;
                        round_o   <= cnt_r;
                        w_valid_o <= 1'b1;
                        cnt_r     <= cnt_r + 6'd1;
                        if (cnt_r == LAST_LOAD) begin
                            state_r    <= ST_EXPAND;
                            in_ready_o <= 1'b0;
                        end else begin
                            state_r    <= ST_LOAD;
                            in_ready_o <= 1'b1;
                        end
                    end else begin
                        // Gap cycle: W_o/round_o keep their last values.
                        w_valid_o <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    W_o       <= expand_s;
                    round_o   <= cnt_r;
                    w_valid_o <= 1'b1;
                    if (cnt_r == LAST_ROUND) begin
                        block_done_o <= 1'b1;
                        state_r      <= ST_LOAD;
                        in_ready_o   <= 1'b1;
                        cnt_r        <= 6'd0;
                    end else begin
                        block_done_o <= 1'b0;
                        state_r      <= ST_EXPAND;
                        in_ready_o   <= 1'b0;
                        cnt_r        <= cnt_r + 6'd1;
                    end
                end
                default: begin
                    state_r      <= ST_LOAD;
                    cnt_r        <= 6'd0;
                    in_ready_o   <= 1'b1;
                    w_valid_o    <= 1'b0;
                    block_done_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHA256_SCHED_OVERRUN_ERR_EN
    // Sticky flag for words offered while the block is not accepting input.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_err_o <= 1'b0;
        end else if (valid_i && !in_ready_o) begin
            overrun_err_o <= 1'b1;
        end else begin
            overrun_err_o <= overrun_err_o;
        end
    end
`endif

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- Downstream neighbour of the SHA-256 preprocessor. Consumes the 16 big-endian 32-bit message words M[0..15] of one 512-bit block.
- Emits the full 64-word message schedule W[0..63], one word per cycle, to the compression-round engine.
- W[0..15] are passed through; W[16..63] are expanded on the fly in a 16-entry sliding window.
- No backpressure on either side: upstream streams words with a valid strobe, and downstream must take one W per cycle while w_valid_o is high.

Parameters:
- WORD_W, 32, word width; fixed by SHA-256, any other value unsupported.
- ROUNDS, 64, schedule length per block; fixed.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- valid_i  input  1  M_i holds a message word this cycle.
- M_i  input  32  message word, M[0] first.
- in_ready_o  output  1  high while the block can accept message words (LOAD state).
- w_valid_o  output  1  W_o/round_o valid this cycle.
- W_o  output  32  schedule word W[t].
- round_o  output  6  index t of W_o (0..63).
- block_done_o  output  1  one-cycle pulse coincident with W[63].

Behaviour:
- Reset: synchronous on clk when rst=1; overrides all other inputs in that cycle.
  - Reset values: state=LOAD, word counter=0, window cleared to 0.
  - Outputs: in_ready_o=1, w_valid_o=0, W_o=0, round_o=0, block_done_o=0.
  - Reset mid-block abandons the block; the next valid_i word is taken as M[0].
- LOAD state (in_ready_o=1):
  - Each cycle with valid_i=1: the word is shifted into the window (win[15] newest, win[0] oldest).
  - Next cycle: W_o=M_i, round_o=cnt, w_valid_o=1, giving 1-cycle latency. Then cnt increments.
  - Gaps in valid_i are allowed; w_valid_o=0 in gap cycles and W_o/round_o hold their last values.
  - When the word with cnt=15 is accepted: next state EXPAND, cnt=16.
- EXPAND state (in_ready_o=0): exactly 48 consecutive cycles, one word per cycle, w_valid_o=1 throughout.
  - W[t] = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32 (carries beyond bit 31 discarded).
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - The new W[t] is registered to W_o and shifted into the window in the same cycle.
  - round_o = t.
  - For t=63: block_done_o=1; next state LOAD, cnt=0, in_ready_o=1 on the following cycle.
- Back-to-back blocks: M[0] of the next block may arrive the first cycle in_ready_o is high. Its W[0] appears one cycle after W[63], with no bubble.
- valid_i=1 while in_ready_o=0: the word is dropped; the window and counter are unaffected.
- Window contents after the block are don't-care; the next block's 16 loads fully overwrite them.
- Throughput: 64 W per block, minimum 64 cycles per block.

Optional Feature:
- Macro: SHA256_SCHED_OVERRUN_ERR_EN.
- Defined:
  - Adds output port overrun_err_o (1 bit), reset 0.
  - Set sticky on any cycle with valid_i=1 and in_ready_o=0; cleared only by rst.
  - Dropped-word behaviour is unchanged.
- Undefined: port absent; dropped words are silently discarded.

Test Plan:
- "abc" block: M0=0x61626380, M1..M14=0, M15=0x00000018 on 16 consecutive cycles.
  - -> W_o, round_o 0..15 echo the inputs at 1-cycle latency.
  - -> W16=0x61626380, W17=0x000F0000.
  - -> W[0..63] match the software reference model.
  - -> block_done_o high only with round_o=63.
- All-zero block -> all 64 W_o=0, w_valid_o high for 64 cycles, in_ready_o low for exactly 48 of them.
- Gapped load: valid_i toggled 1,0,1,0... over 32 cycles -> W[0..15] appear only after valid cycles; expansion starts the cycle after M15 is accepted.
- Back-to-back: two blocks, second M0 presented the cycle in_ready_o rises -> 128 consecutive w_valid_o cycles, round_o wraps 63->0.
- Overrun: valid_i=1, M_i=0xDEADBEEF during EXPAND -> output stream unchanged; with SHA256_SCHED_OVERRUN_ERR_EN, overrun_err_o=1 until rst.
- Reset mid-EXPAND (at round 30) -> next cycle w_valid_o=0, in_ready_o=1, round_o=0; the following block produces a correct schedule.
